// File: rtl/palt_nios_gpio_seq_pkg.sv
// Shared constants and types for the Nios PIO output-pattern sequencer.
// Register map, CTRL bit positions and the sequencer FSM state encoding.
package palt_nios_gpio_seq_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_LENGTH  = 2'd3;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_LOOP = 1;
    localparam int unsigned CTRL_BUSY = 2;
    localparam int unsigned CTRL_DONE = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/palt_nios_gpio_seq_timer.sv
// Loadable down-counter that paces the gap between sequencer PIO writes.
// Load wins over count; the counter stops at zero.
module palt_nios_gpio_seq_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_value;
        end else if (i_en && (r_value != '0)) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);

endmodule

// File: rtl/palt_nios_gpio_seq.sv
// Autonomous 2-bit PIO pattern sequencer: Avalon-MM config slave plus a
// single-cycle-write Avalon-MM master aimed at PIO register 0.
module palt_nios_gpio_seq
    import palt_nios_gpio_seq_pkg::*;
#(
    parameter int unsigned PERIOD_W  = 16,
    parameter int unsigned MAX_STEPS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
);

    localparam int unsigned LEN_W = $clog2(MAX_STEPS);
    localparam int unsigned PAT_W = 2 * MAX_STEPS;

    logic                r_en;
    logic                r_loop;
    logic                r_done;
    logic [PERIOD_W-1:0] r_period;
    logic [PAT_W-1:0]    r_pattern;
    logic [LEN_W-1:0]    r_length;

    logic [PERIOD_W-1:0] r_wk_period;
    logic [PAT_W-1:0]    r_wk_pattern;
    logic [LEN_W-1:0]    r_wk_length;
    logic                r_wk_loop;
    logic [LEN_W-1:0]    r_step;
    seq_state_t          r_state;

    logic                r_m_cs;
    logic                r_m_wn;
    logic [1:0]          r_m_data;

    logic                w_wr;
    logic                w_ctrl_wr;
    logic                w_busy;
    logic                w_start;
    logic                w_abort;
    logic                w_short;
    logic                w_step_end;
    logic                w_last;
    logic                w_finish;
    logic                w_timer_load;
    logic                w_timer_en;
    logic                w_timer_zero;
    logic [PERIOD_W-1:0] w_timer_value;
    logic [LEN_W-1:0]    w_next_step;

    always_comb begin
        w_wr         = s_chipselect && !s_write_n;
        w_ctrl_wr    = w_wr && (s_address == ADDR_CTRL);
        w_busy       = (r_state != ST_IDLE);
        w_start      = w_ctrl_wr && s_writedata[CTRL_EN] && !w_busy;
        w_abort      = w_ctrl_wr && !s_writedata[CTRL_EN] && w_busy;
        // A latched period of 0 behaves exactly like 1: back-to-back writes.
        w_short      = (r_wk_period <= PERIOD_W'(1));
        w_step_end   = ((r_state == ST_WRITE) && w_short) ||
                       ((r_state == ST_WAIT) && (w_timer_value == '0));
        w_last       = (r_step == r_wk_length);
        w_finish     = w_step_end && w_last && !r_wk_loop && !w_abort;
        w_timer_load = (r_state == ST_WRITE) && !w_short && !w_abort;
        w_timer_en   = (r_state == ST_WAIT) && !w_timer_zero;
        w_next_step  = w_last ? '0 : r_step + 1'b1;
    end

    palt_nios_gpio_seq_timer #(
        .WIDTH (PERIOD_W)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_timer_load),
        .i_load_value (r_wk_period - PERIOD_W'(2)),
        .i_en         (w_timer_en),
        .o_value      (w_timer_value),
        .o_zero       (w_timer_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= 1'b0;
            r_loop    <= 1'b0;
            r_done    <= 1'b0;
            r_period  <= PERIOD_W'(1);
            r_pattern <= '0;
            r_length  <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en   <= s_writedata[CTRL_EN];
                r_loop <= s_writedata[CTRL_LOOP];
                r_done <= 1'b0;
            end
            if (w_finish) begin
                r_en   <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_wr && (s_address == ADDR_PERIOD))  r_period  <= s_writedata[PERIOD_W-1:0];
            if (w_wr && (s_address == ADDR_PATTERN)) r_pattern <= s_writedata[PAT_W-1:0];
            if (w_wr && (s_address == ADDR_LENGTH))  r_length  <= s_writedata[LEN_W-1:0];
        end
    end

    // Master strobes are issued on the transition into WRITE so they stay registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_wk_period  <= PERIOD_W'(1);
            r_wk_pattern <= '0;
            r_wk_length  <= '0;
            r_wk_loop    <= 1'b0;
            r_m_cs       <= 1'b0;
            r_m_wn       <= 1'b1;
            r_m_data     <= '0;
        end else begin
            r_m_cs <= 1'b0;
            r_m_wn <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_wk_period  <= r_period;
                        r_wk_pattern <= r_pattern;
                        r_wk_length  <= r_length;
                        r_wk_loop    <= s_writedata[CTRL_LOOP];
                        r_step       <= '0;
                        r_state      <= ST_WRITE;
                        r_m_cs       <= 1'b1;
                        r_m_wn       <= 1'b0;
                        r_m_data     <= r_pattern[1:0];
                    end
                end
                ST_WRITE, ST_WAIT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_step_end) begin
                        if (w_last && !r_wk_loop) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_step   <= w_next_step;
                            r_state  <= ST_WRITE;
                            r_m_cs   <= 1'b1;
                            r_m_wn   <= 1'b0;
                            r_m_data <= r_wk_pattern[{w_next_step, 1'b0} +: 2];
                        end
                    end else if (r_state == ST_WRITE) begin
                        r_state <= ST_WAIT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_readdata = '0;
        unique case (s_address)
            ADDR_CTRL: begin
                s_readdata[CTRL_EN]   = r_en;
                s_readdata[CTRL_LOOP] = r_loop;
                s_readdata[CTRL_BUSY] = w_busy;
                s_readdata[CTRL_DONE] = r_done;
            end
            ADDR_PERIOD:  s_readdata[PERIOD_W-1:0] = r_period;
            ADDR_PATTERN: s_readdata[PAT_W-1:0]    = r_pattern;
            ADDR_LENGTH:  s_readdata[LEN_W-1:0]    = r_length;
            default:      s_readdata = '0;
        endcase
    end

    assign m_address    = '0;
    assign m_chipselect = r_m_cs;
    assign m_write_n    = r_m_wn;
    assign m_writedata  = {30'b0, r_m_data};

endmodule

// File: tb/tb_palt_nios_gpio_seq.sv
// Self-checking bench for palt_nios_gpio_seq: expected PIO writes are queued
// when a run is started and popped by a monitor as strobes appear.
module tb_palt_nios_gpio_seq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    typedef struct {
        logic [15:0] pat;
        logic [2:0]  len;
        logic [15:0] per;
        int          done_ofs;
    } vec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rb_t;

    typedef struct {
        int         cyc;
        logic [1:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    palt_nios_gpio_seq #(
        .PERIOD_W  (16),
        .MAX_STEPS (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // PIO-side monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && m_chipselect) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pio_unexpected: write 0x%0h at cycle %0d, required no write", m_writedata, cyc);
            end else begin
                e = sb.pop_front();
                check("pio_cycle", cyc, e.cyc);
                check("pio_data", m_writedata, {30'b0, e.d});
                check("pio_wrn_addr", {29'b0, m_write_n, m_address}, 32'h0);
            end
        end
    end

    // Callers are always positioned at a falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        s_address = a;
        #1;
        check(name, s_readdata, exp);
    endtask

    task automatic program_cfg(input logic [15:0] pat, input logic [2:0] len, input logic [15:0] per);
        wr(2'd1, {16'b0, per});
        wr(2'd2, {16'b0, pat});
        wr(2'd3, {29'b0, len});
    endtask

    task automatic start_push(input logic [15:0] pat, input logic [2:0] len, input logic [15:0] per,
                              input logic [31:0] ctrl, input int nw, output int t);
        int p;
        int step;
        exp_t e;
        p = (per == 16'd0) ? 1 : int'(per);
        t = cyc;
        for (int k = 0; k < nw; k++) begin
            step  = k % (int'(len) + 1);
            e.cyc = t + 1 + k * p;
            e.d   = pat[2*step +: 2];
            sb.push_back(e);
        end
        wr(2'd0, ctrl);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic finish_check(input string name, input int td);
        wait_until(td - 1);
        rd_check({name, "_busy"}, 2'd0, 32'h5);
        @(negedge clk);
        rd_check({name, "_done"}, 2'd0, 32'h8);
        check({name, "_all_writes"}, sb.size(), 0);
    endtask

    vec_t vecs[5];
    rb_t  rbs[4];
    int   t;

    initial begin
        vecs[0] = '{16'h00E4, 3'd3, 16'd4, 17};
        vecs[1] = '{16'h001B, 3'd0, 16'd1, 2};
        vecs[2] = '{16'hC6A5, 3'd7, 16'd2, 17};
        vecs[3] = '{16'h0055, 3'd2, 16'd0, 4};
        vecs[4] = '{16'h009C, 3'd5, 16'd3, 19};
        rbs[0]  = '{2'd0, 32'h0};
        rbs[1]  = '{2'd1, 32'h1};
        rbs[2]  = '{2'd2, 32'h0};
        rbs[3]  = '{2'd3, 32'h0};

        reset_n      = 1'b0;
        s_address    = 2'd0;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        s_writedata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_m_cs", {31'b0, m_chipselect}, 32'h0);
        check("rst_m_wrn", {31'b0, m_write_n}, 32'h1);
        check("rst_m_addr", {30'b0, m_address}, 32'h0);
        check("rst_m_data", m_writedata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) rd_check("rst_readback", rbs[i].addr, rbs[i].exp);

        // One-shot runs from the vector table.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            program_cfg(vecs[i].pat, vecs[i].len, vecs[i].per);
            start_push(vecs[i].pat, vecs[i].len, vecs[i].per, 32'h1, int'(vecs[i].len) + 1, t);
            finish_check("oneshot", t + vecs[i].done_ofs);
        end

        // Looping with period 0, then abort.
        @(negedge clk);
        program_cfg(16'h0006, 3'd1, 16'd0);
        start_push(16'h0006, 3'd1, 16'd0, 32'h3, 8, t);
        wait_until(t + 8);
        wr(2'd0, 32'h0);
        check("loop_abort_writes", sb.size(), 0);
        rd_check("loop_abort_ctrl", 2'd0, 32'h0);
        repeat (4) @(negedge clk);

        // Reconfiguration during a run only affects the next run.
        program_cfg(16'h00E4, 3'd3, 16'd3);
        start_push(16'h00E4, 3'd3, 16'd3, 32'h1, 4, t);
        wr(2'd2, 32'h001B);
        wr(2'd1, 32'h2);
        finish_check("reconf_old", t + 13);
        rd_check("reconf_pattern", 2'd2, 32'h1B);
        @(negedge clk);
        start_push(16'h001B, 3'd3, 16'd2, 32'h1, 4, t);
        finish_check("reconf_new", t + 9);

        // Abort on the cycle the final WAIT would complete.
        @(negedge clk);
        program_cfg(16'h000D, 3'd1, 16'd3);
        start_push(16'h000D, 3'd1, 16'd3, 32'h1, 2, t);
        wait_until(t + 6);
        wr(2'd0, 32'h0);
        rd_check("abort_last_ctrl", 2'd0, 32'h0);
        check("abort_last_writes", sb.size(), 0);
        repeat (4) @(negedge clk);

        // Restart attempt while busy is ignored.
        program_cfg(16'h00E4, 3'd3, 16'd2);
        start_push(16'h00E4, 3'd3, 16'd2, 32'h1, 4, t);
        wait_until(t + 2);
        wr(2'd0, 32'h1);
        finish_check("restart_busy", t + 9);

        // Asynchronous reset during WAIT.
        @(negedge clk);
        program_cfg(16'h00E4, 3'd3, 16'd4);
        start_push(16'h00E4, 3'd3, 16'd4, 32'h1, 1, t);
        wait_until(t + 3);
        reset_n = 1'b0;
        #1;
        check("arst_m_cs", {31'b0, m_chipselect}, 32'h0);
        check("arst_m_wrn", {31'b0, m_write_n}, 32'h1);
        check("arst_m_data", m_writedata, 32'h0);
        for (int i = 0; i < 4; i++) rd_check("arst_readback", rbs[i].addr, rbs[i].exp);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_writes", sb.size(), 0);
        program_cfg(16'h00E4, 3'd3, 16'd4);
        start_push(16'h00E4, 3'd3, 16'd4, 32'h1, 4, t);
        finish_check("arst_rerun", t + 17);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
